// File: rtl/counting_seq_gen.sv
// counting_seq_gen: drives a 2-bit symbol stream of {1,2,3} triples separated by
// 0-filler gaps. It also carries a mirror of the downstream 1->2->3 receiver and
// counts how many times that mirror enters its accept state.
module counting_seq_gen #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] rep,
    input  logic [GAP_W-1:0] gap,
    output logic [1:0]       num,
    output logic             busy,
    output logic             done,
    output logic             ans_mir,
    output logic [CNT_W-1:0] hits
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_q;
    logic [CNT_W-1:0] tcnt;   // index of the triple being sent, starting at 1
    logic [GAP_W-1:0] gcnt;   // index of the filler symbol being sent, starting at 1
    logic [1:0]       ms;
    logic [1:0]       ms_nxt;
    logic             accept;

    assign accept  = (state == ST_IDLE) && start;
    assign ans_mir = (ms == 2'd3);

    // Main sequencer: outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            num   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rep_q <= '0;
            gap_q <= '0;
            tcnt  <= '0;
            gcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    num  <= '0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        rep_q <= rep;
                        gap_q <= gap;
                        tcnt  <= CNT_W'(1);
                        if (rep != '0) begin
                            state <= ST_S1;
                            num   <= 2'd1;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_S1: begin
                    state <= ST_S2;
                    num   <= 2'd2;
                end
                ST_S2: begin
                    state <= ST_S3;
                    num   <= 2'd3;
                end
                ST_S3: begin
                    if (tcnt == rep_q) begin
                        state <= ST_DONE;
                        num   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_q != '0) begin
                        state <= ST_GAP;
                        num   <= '0;
                        gcnt  <= GAP_W'(1);
                        tcnt  <= tcnt + 1'b1;
                    end else begin
                        state <= ST_S1;
                        num   <= 2'd1;
                        tcnt  <= tcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gcnt == gap_q) begin
                        state <= ST_S1;
                        num   <= 2'd1;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    num   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Receiver mirror next state, driven by the registered symbol stream
    always_comb begin
        ms_nxt = ms;
        case (num)
            2'd1: ms_nxt = 2'd1;
            2'd2: begin
                if (ms == 2'd1 || ms == 2'd2) ms_nxt = 2'd2;
                else if (ms == 2'd3)          ms_nxt = 2'd0;
            end
            2'd3: begin
                if (ms == 2'd2 || ms == 2'd3) ms_nxt = 2'd3;
                else if (ms == 2'd1)          ms_nxt = 2'd0;
            end
            default: ms_nxt = ms;
        endcase
    end

    // Mirror state and accept-event counter; hits restarts on each accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            ms   <= '0;
            hits <= '0;
        end else begin
            ms <= ms_nxt;
            if (accept)
                hits <= '0;
            else if (ms != 2'd3 && ms_nxt == 2'd3)
                hits <= hits + 1'b1;
        end
    end

endmodule
